// File: rtl/svm_result_packer_pkg.sv
// Shared types, field positions and beat-packing helpers for the SVM result packer.
package svm_result_pkg;

  localparam int SW_ID_W      = 11;   // slide-window id width
  localparam int SW_NUM       = 495;  // classifier results per frame (33 x 15)
  localparam int FIFO_DEPTH   = 16;   // detection FIFO entries (power of 2)
  localparam int FRAME_ID_W   = 16;   // frame counter width
  localparam int AXIS_TDATA_W = 32;   // output beat width
  localparam int CNT_W        = 12;   // header count field width
  localparam int TRL_CNT_W    = 16;   // trailer counter width

  // Header beat field positions
  localparam int HDR_FID_LSB    = 16;
  localparam int HDR_OVF_BIT    = 15;
  localparam int HDR_MERGED_BIT = 14;
  localparam int HDR_CNT_LSB    = 0;

  // Detection beat field positions
  localparam int DET_FID_LSB = 16;
  localparam int DET_ID_LSB  = 0;

  // Trailer beat field positions
  localparam int TRL_RAW_LSB  = 16;
  localparam int TRL_DROP_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    TRL  = 2'd3
  } state_t;

  typedef struct packed {
    logic [FRAME_ID_W-1:0] frame_id;
    logic                  ovf;
    logic                  merged;
    logic [CNT_W-1:0]      count;
  } hdr_t;

  function automatic logic [AXIS_TDATA_W-1:0] pack_hdr(input hdr_t h);
    logic [AXIS_TDATA_W-1:0] b;
    b = '0;
    b[HDR_FID_LSB +: FRAME_ID_W] = h.frame_id;
    b[HDR_OVF_BIT]               = h.ovf;
    b[HDR_MERGED_BIT]            = h.merged;
    b[HDR_CNT_LSB +: CNT_W]      = h.count;
    return b;
  endfunction

  function automatic logic [AXIS_TDATA_W-1:0] pack_det(input logic [FRAME_ID_W-1:0] fid,
                                                       input logic [SW_ID_W-1:0] id);
    logic [AXIS_TDATA_W-1:0] b;
    b = '0;
    b[DET_FID_LSB +: FRAME_ID_W] = fid;
    b[DET_ID_LSB +: SW_ID_W]     = id;
    return b;
  endfunction

  function automatic logic [AXIS_TDATA_W-1:0] pack_trl(input logic [TRL_CNT_W-1:0] raw,
                                                       input logic [TRL_CNT_W-1:0] dropped);
    logic [AXIS_TDATA_W-1:0] b;
    b = '0;
    b[TRL_RAW_LSB +: TRL_CNT_W]  = raw;
    b[TRL_DROP_LSB +: TRL_CNT_W] = dropped;
    return b;
  endfunction

  // Saturating add used by the per-frame trailer counters and their merge.
  function automatic logic [TRL_CNT_W-1:0] sat_add(input logic [TRL_CNT_W-1:0] a,
                                                   input logic [TRL_CNT_W-1:0] b);
    logic [TRL_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TRL_CNT_W] ? {TRL_CNT_W{1'b1}} : s[TRL_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/svm_result_packer_if.sv
// AXI-Stream result channel between the packer (master) and the DMA/host path (slave).
interface svm_result_packer_if;
  import svm_result_pkg::*;

  logic [AXIS_TDATA_W-1:0] m_tdata_o;
  logic                    m_tvalid_o;
  logic                    m_tlast_o;
  logic                    m_tready_i;

  modport master (output m_tdata_o, output m_tvalid_o, output m_tlast_o, input m_tready_i);
  modport slave  (input m_tdata_o, input m_tvalid_o, input m_tlast_o, output m_tready_i);
endinterface

// File: rtl/svm_result_packer_det_fifo.sv
// Detection-id FIFO: synchronous, registered first-word read data. A write into
// the slot about to be presented is forwarded so it is poppable one cycle later.
module det_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [W-1:0]  rd_data_reg;
  logic          wr_ok, rd_ok;

  assign full        = (count_reg == (AW+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign wr_ok       = wr_en & ~full;
  assign rd_ok       = rd_en & ~empty;
  assign rd_ptr_next = rd_ptr_reg + AW'(rd_ok);
  assign rd_data     = rd_data_reg;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(wr_ok);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  // Registered head-of-queue data, forwarding a same-slot write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (wr_ok && (wr_ptr_reg == rd_ptr_next)) begin
      rd_data_reg <= wr_data;
    end else begin
      rd_data_reg <= mem[rd_ptr_next];
    end
  end
endmodule

// File: rtl/svm_result_packer.sv
// Per-frame SVM result packer: collects positive window ids into a FIFO and
// emits one AXI-Stream packet per frame (header + one beat per detection).
// Optional feature macro: SVM_RESULT_TRAILER_EN adds a trailer beat carrying
// raw and dropped positive counts; tlast then moves to the trailer.
module svm_result_packer
  import svm_result_pkg::*;
(
  input  logic                s_aclk,
  input  logic                s_aresetn,
  input  logic                svm_valid_i,
  input  logic                svm_person_i,
  input  logic [SW_ID_W-1:0]  svm_sw_id_i,
  svm_result_packer_if.master m_axis,
  output logic                frame_done_o
);
  localparam int WCNT_W = $clog2(SW_NUM);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SW_NUM - 1);
`ifdef SVM_RESULT_TRAILER_EN
  localparam bit TRAILER = 1'b1;
`else
  localparam bit TRAILER = 1'b0;
`endif

  logic [WCNT_W-1:0]     wcnt_reg;
  logic [FRAME_ID_W-1:0] frame_id_reg;
  logic [CNT_W-1:0]      stored_reg;
  logic                  ovf_reg;
  logic                  pend_valid_reg;
  hdr_t                  pend_reg, active_reg;
  logic [CNT_W-1:0]      rem_reg;
  state_t                state_reg, state_next;
  logic                  frame_done_reg;

  logic                  fifo_full, fifo_empty;
  logic [SW_ID_W-1:0]    fifo_rd_data;
  logic                  pos_hit, push, drop, frame_end, take, pop, hs;
  logic [CNT_W-1:0]      stored_final;
  logic                  ovf_final;
  logic [AXIS_TDATA_W-1:0] tdata;
  logic                  tvalid, tlast;

  // Fullness is taken before any same-cycle pop, so a push at full is dropped.
  assign pos_hit      = svm_valid_i & svm_person_i;
  assign push         = pos_hit & ~fifo_full;
  assign drop         = pos_hit & fifo_full;
  assign frame_end    = svm_valid_i & (wcnt_reg == WCNT_LAST);
  assign stored_final = stored_reg + CNT_W'(push);
  assign ovf_final    = ovf_reg | drop;
  assign hs           = tvalid & m_axis.m_tready_i;

  det_fifo #(.DEPTH(FIFO_DEPTH), .W(SW_ID_W)) u_det_fifo (
    .clk     (s_aclk),
    .rst_n   (s_aresetn),
    .wr_en   (push),
    .wr_data (svm_sw_id_i),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Window counter, frame id, per-frame stats and the frame-end pulse
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      wcnt_reg       <= '0;
      frame_id_reg   <= '0;
      stored_reg     <= '0;
      ovf_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (frame_end) begin
        wcnt_reg     <= '0;
        frame_id_reg <= frame_id_reg + 1'b1;
        stored_reg   <= '0;
        ovf_reg      <= 1'b0;
      end else begin
        if (svm_valid_i) wcnt_reg <= wcnt_reg + 1'b1;
        stored_reg <= stored_final;
        ovf_reg    <= ovf_final;
      end
    end
  end

  // Pending header slot: latch at frame end, merge if still unclaimed
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
    end else if (frame_end) begin
      pend_valid_reg <= 1'b1;
      if (pend_valid_reg && !take) begin
        pend_reg.count  <= pend_reg.count + stored_final;
        pend_reg.ovf    <= pend_reg.ovf | ovf_final;
        pend_reg.merged <= 1'b1;
      end else begin
        pend_reg.frame_id <= frame_id_reg;
        pend_reg.ovf      <= ovf_final;
        pend_reg.merged   <= 1'b0;
        pend_reg.count    <= stored_final;
      end
    end else if (take) begin
      pend_valid_reg <= 1'b0;
    end
  end

  // Active packet header and remaining-detection counter
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      active_reg <= '0;
      rem_reg    <= '0;
    end else if (take) begin
      active_reg <= pend_reg;
      rem_reg    <= pend_reg.count;
    end else if (state_reg == BODY && hs) begin
      rem_reg <= rem_reg - 1'b1;
    end
  end

`ifdef SVM_RESULT_TRAILER_EN
  logic [TRL_CNT_W-1:0] raw_reg, drop_reg, pend_raw_reg, pend_drop_reg;
  logic [TRL_CNT_W-1:0] act_raw_reg, act_drop_reg, raw_final, drop_final;

  assign raw_final  = sat_add(raw_reg, TRL_CNT_W'(pos_hit));
  assign drop_final = sat_add(drop_reg, TRL_CNT_W'(drop));

  // Trailer statistics: per frame, pending (merged like stored), active
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      raw_reg       <= '0;
      drop_reg      <= '0;
      pend_raw_reg  <= '0;
      pend_drop_reg <= '0;
      act_raw_reg   <= '0;
      act_drop_reg  <= '0;
    end else begin
      if (take) begin
        act_raw_reg  <= pend_raw_reg;
        act_drop_reg <= pend_drop_reg;
      end
      if (frame_end) begin
        raw_reg  <= '0;
        drop_reg <= '0;
        if (pend_valid_reg && !take) begin
          pend_raw_reg  <= sat_add(pend_raw_reg, raw_final);
          pend_drop_reg <= sat_add(pend_drop_reg, drop_final);
        end else begin
          pend_raw_reg  <= raw_final;
          pend_drop_reg <= drop_final;
        end
      end else begin
        raw_reg  <= raw_final;
        drop_reg <= drop_final;
      end
    end
  end
`endif

  // Emitter state register
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Emitter next state, pending-slot claim and FIFO pop
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          take       = 1'b1;
          state_next = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          if (active_reg.count != '0) state_next = BODY;
          else                        state_next = TRAILER ? TRL : IDLE;
        end
      end
      BODY: begin
        if (hs) begin
          pop = ~fifo_empty;
          if (rem_reg == CNT_W'(1)) state_next = TRAILER ? TRL : IDLE;
        end
      end
      TRL: begin
        if (hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat formatting from registered state only; stable until handshake
  always_comb begin
    tdata = '0;
    tlast = 1'b0;
    case (state_reg)
      HDR: begin
        tdata = pack_hdr(active_reg);
        tlast = !TRAILER && (active_reg.count == '0);
      end
      BODY: begin
        tdata = pack_det(active_reg.frame_id, fifo_rd_data);
        tlast = !TRAILER && (rem_reg == CNT_W'(1));
      end
      TRL: begin
`ifdef SVM_RESULT_TRAILER_EN
        tdata = pack_trl(act_raw_reg, act_drop_reg);
`endif
        tlast = 1'b1;
      end
      default: begin
        tdata = '0;
        tlast = 1'b0;
      end
    endcase
  end

  assign tvalid            = (state_reg != IDLE);
  assign m_axis.m_tdata_o  = tdata;
  assign m_axis.m_tvalid_o = tvalid;
  assign m_axis.m_tlast_o  = tlast;
  assign frame_done_o      = frame_done_reg;

endmodule
